taxi_apb_reg_bridge: RTL

TAXI_APB_REG_BRIDGE -- requirements
Module: taxi_apb_reg_bridge

---
 rtl/taxi_apb_if.sv | 35 +++
 rtl/taxi_apb_reg_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/taxi_apb_if.sv
// APB bus interface bundle: requester/completer signal set with optional user sidebands.
interface taxi_apb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int STRB_W   = DATA_W/8,
  parameter int PAUSER_W = 1,
  parameter int PWUSER_W = 1,
  parameter int PRUSER_W = 1,
  parameter int PBUSER_W = 1
) ();
  logic [ADDR_W-1:0]   paddr;
  logic [2:0]          pprot;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [STRB_W-1:0]   pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;
  logic [PAUSER_W-1:0] pauser;
  logic [PWUSER_W-1:0] pwuser;
  logic [PRUSER_W-1:0] pruser;
  logic [PBUSER_W-1:0] pbuser;

  modport mst (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    input  pready, prdata, pslverr, pruser, pbuser
  );

  modport slv (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    output pready, prdata, pslverr, pruser, pbuser
  );
endinterface

// File: rtl/taxi_apb_reg_bridge.sv
// APB completer to simple local register strobe/ack bus, with ack timeout.
module taxi_apb_reg_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  taxi_apb_if.slv                   s_apb,
  output logic [s_apb.ADDR_W-1:0]   reg_addr,
  output logic [s_apb.DATA_W-1:0]   reg_wr_data,
  output logic [s_apb.STRB_W-1:0]   reg_wr_strb,
  output logic                      reg_wr_en,
  input  logic                      reg_wr_ack,
  output logic                      reg_rd_en,
  input  logic [s_apb.DATA_W-1:0]   reg_rd_data,
  input  logic                      reg_rd_ack
);

  localparam int ADDR_W = s_apb.ADDR_W;
  localparam int DATA_W = s_apb.DATA_W;
  localparam int STRB_W = s_apb.STRB_W;
  // A zero TIMEOUT still needs a legal one-bit counter even though it is never used.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if (STRB_W * 8 != DATA_W) begin : g_strb_chk
    $fatal(1, "taxi_apb_reg_bridge: STRB_W*8 must equal DATA_W");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              wr_en_reg, wr_en_next;
  logic              rd_en_reg, rd_en_next;
  logic              pready_reg, pready_next;
  logic              pslverr_reg, pslverr_next;
  logic [DATA_W-1:0] prdata_reg, prdata_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [STRB_W-1:0] wr_strb_reg;
  logic              write_reg;
  logic              skip_reg;
  logic              capture;
  logic              ack_ok;

  // Protection and user request sidebands carry nothing for the local bus.
  wire unused_apb = ^{s_apb.pprot, s_apb.pauser, s_apb.pwuser};

  assign s_apb.pready  = pready_reg;
  assign s_apb.pslverr = pslverr_reg;
  assign s_apb.prdata  = prdata_reg;
  assign s_apb.pruser  = '0;
  assign s_apb.pbuser  = '0;

  assign reg_addr    = addr_reg;
  assign reg_wr_data = wr_data_reg;
  assign reg_wr_strb = wr_strb_reg;
  assign reg_wr_en   = wr_en_reg;
  assign reg_rd_en   = rd_en_reg;

  // Only the ack matching the captured direction counts.
  assign ack_ok = write_reg ? reg_wr_ack : reg_rd_ack;

  // Next-state and registered-output logic; responses are zero unless entering RESP.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    prdata_next  = '0;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_apb.psel && !s_apb.penable) begin
          capture    = 1'b1;
          state_next = ACCESS;
          cnt_next   = '0;
          if (s_apb.pwrite) begin
            // An all-zero strobe write touches nothing; it completes without a strobe.
            wr_en_next = |s_apb.pstrb;
          end else begin
            rd_en_next = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!s_apb.psel) begin
          state_next = IDLE;
        end else if (skip_reg) begin
          state_next  = RESP;
          pready_next = 1'b1;
        end else if (ack_ok) begin
          // Ack takes priority over a timeout expiring in the same cycle.
          state_next  = RESP;
          pready_next = 1'b1;
          if (!write_reg) begin
            prdata_next = reg_rd_data;
          end
        end else if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
          state_next   = RESP;
          pready_next  = 1'b1;
          pslverr_next = 1'b1;
        end else if (cnt_reg != {CNT_W{1'b1}}) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state and APB response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wr_en_reg   <= wr_en_next;
      rd_en_reg   <= rd_en_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
      prdata_reg  <= prdata_next;
    end
  end

  // Request capture at the setup phase; held until the next setup.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_reg    <= s_apb.paddr;
      wr_data_reg <= s_apb.pwdata;
      wr_strb_reg <= s_apb.pstrb;
      write_reg   <= s_apb.pwrite;
      skip_reg    <= s_apb.pwrite && (s_apb.pstrb == '0);
    end
  end

endmodule
